instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 76 +++++++
 tb/tb_instr_fetch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program memory loaded while in LOAD, then fetched from
// PC in RUN with in-fetch JUMP/HALT decode. Leaves HALT only through Reset.
module instr_fetch_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Prog_We,
    input  logic [ADDR_W-1:0] Prog_Addr,
    input  logic [DATA_W-1:0] Prog_Data,
    input  logic              Start,
    input  logic              Stall,
    output logic [DATA_W-1:0] Instr_Code,
    output logic              Instr_Valid,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cur;
    logic              is_ctl, is_jump, is_halt;

    assign cur     = mem[PC];
    // Top two bits 11 mark a control instruction; the next bit picks HALT over JUMP.
    assign is_ctl  = (cur[DATA_W-1 -: 2] == 2'b11);
    assign is_jump = is_ctl & ~cur[DATA_W-3];
    assign is_halt = is_ctl &  cur[DATA_W-3];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_LOAD;
            PC    <= '0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
        end
    end

    // Reset wipes the program too, so every run needs a fresh load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == S_LOAD && Prog_We) begin
            mem[Prog_Addr] <= Prog_Data;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        case (state)
            S_LOAD: begin
                pc_nxt = '0;
                if (Start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!Stall) begin
                    if (is_halt)      state_nxt = S_HALT;
                    else if (is_jump) pc_nxt = cur[ADDR_W-1:0];
                    else              pc_nxt = PC + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Instr_Valid = (state == S_RUN);
    assign Instr_Code  = Instr_Valid ? cur : '0;
    assign Halted      = (state == S_HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: straight-line run, jump, wrap, stall, mid-run reset.
module tb_instr_fetch_unit;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Prog_We = 1'b0;
    logic [4:0] Prog_Addr = '0;
    logic [7:0] Prog_Data = '0;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic [7:0] Instr_Code;
    logic       Instr_Valid;
    logic [4:0] PC;
    logic       Halted;

    int n_chk = 0;
    int n_fail = 0;

    instr_fetch_unit #(.ADDR_W(5), .DATA_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Prog_We(Prog_We), .Prog_Addr(Prog_Addr),
        .Prog_Data(Prog_Data), .Start(Start), .Stall(Stall), .Instr_Code(Instr_Code),
        .Instr_Valid(Instr_Valid), .PC(PC), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        #2 Reset = 1'b0;
        #2 Reset = 1'b1;
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] d);
        Prog_We = 1'b1; Prog_Addr = a; Prog_Data = d;
        tick();
        Prog_We = 1'b0;
    endtask

    task automatic start;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic chk_run(input string tag, input logic [4:0] pc, input logic [7:0] code);
        chk({tag, "_pc"}, PC, pc);
        chk({tag, "_code"}, Instr_Code, code);
        chk({tag, "_vld"}, Instr_Valid, 1'b1);
        chk({tag, "_hlt"}, Halted, 1'b0);
    endtask

    initial begin
        // Reset state, reached before any clock edge
        #3;
        chk("rst_pc", PC, 0);
        chk("rst_code", Instr_Code, 0);
        chk("rst_vld", Instr_Valid, 0);
        chk("rst_hlt", Halted, 0);
        #4 Reset = 1'b1;

        // Straight-line program ending in HALT
        load(0, 8'h41); load(1, 8'h52); load(2, 8'h63); load(3, 8'hE0);
        chk("load_vld", Instr_Valid, 0);
        chk("load_code", Instr_Code, 0);
        start();
        chk_run("seq0", 0, 8'h41); tick();
        chk_run("seq1", 1, 8'h52); tick();
        chk_run("seq2", 2, 8'h63); tick();
        chk_run("seq3", 3, 8'hE0); tick();
        chk("halt_hlt", Halted, 1);
        chk("halt_pc", PC, 3);
        chk("halt_code", Instr_Code, 0);
        chk("halt_vld", Instr_Valid, 0);
        Start = 1'b1; tick(); Start = 1'b0; tick();
        chk("halt_sticky", Halted, 1);
        chk("halt_pc2", PC, 3);

        // Jump, with the last write coinciding with Start
        do_reset();
        chk("rst2_hlt", Halted, 0);
        load(0, 8'hC5); load(5, 8'h12);
        Prog_We = 1'b1; Prog_Addr = 6; Prog_Data = 8'hE0; Start = 1'b1;
        tick();
        Prog_We = 1'b0; Start = 1'b0;
        chk_run("jmp0", 0, 8'hC5); tick();
        chk_run("jmp5", 5, 8'h12); tick();
        chk_run("jmp6", 6, 8'hE0); tick();
        chk("jmp_hlt", Halted, 1);
        chk("jmp_pc", PC, 6);

        // Wrap-around over the full memory
        do_reset();
        for (int i = 0; i < 32; i++) load(i[4:0], 8'h01);
        start();
        for (int i = 0; i < 34; i++) begin
            chk("wrap_pc", PC, i % 32);
            chk("wrap_vld", Instr_Valid, 1);
            tick();
        end

        // Stall while a JUMP sits at PC=2; RUN-time writes must be ignored
        do_reset();
        load(0, 8'h01); load(1, 8'h01); load(2, 8'hC9); load(9, 8'hE0);
        start();
        tick();
        chk_run("stl_pre", 1, 8'h01);
        tick();
        Stall = 1'b1;
        Prog_We = 1'b1; Prog_Addr = 9; Prog_Data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            chk_run("stall", 2, 8'hC9);
            tick();
        end
        Stall = 1'b0; Prog_We = 1'b0;
        chk_run("stl_rel", 2, 8'hC9);
        tick();
        chk_run("stl_tgt", 9, 8'hE0);

        // Jump-to-self loops, then reset between edges mid-run
        do_reset();
        load(0, 8'hC0);
        start();
        for (int i = 0; i < 4; i++) begin
            chk_run("self", 0, 8'hC0);
            tick();
        end
        load(1, 8'h77);
        #2 Reset = 1'b0;
        #1;
        chk("mid_pc", PC, 0);
        chk("mid_vld", Instr_Valid, 0);
        chk("mid_code", Instr_Code, 0);
        chk("mid_hlt", Halted, 0);
        Prog_We = 1'b1; Prog_Addr = 0; Prog_Data = 8'h77;
        tick(); tick();
        Prog_We = 1'b0;
        chk("mid_hold_vld", Instr_Valid, 0);
        #2 Reset = 1'b1;
        start();
        chk_run("wiped0", 0, 8'h00); tick();
        chk_run("wiped1", 1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
